stream_mux_arb: RTL and testbench
=================================

Name: stream_mux_arb

Overview:
- Parametrised N-channel, WIDTH-bit registered stream multiplexer. Successor to the team's fixed 2-/4-way 32-bit combinational selectors.
- Adds valid/ready handshakes, one output register stage, and a selectable mode: external select or round-robin arbitration.
- Sits between multiple producers (e.g. writeback sources, bus masters) and a single consumer in the CPU datapath.

Parameters:
- WIDTH, 32, data width of every channel.
- N, 4, number of input channels, 2..16; need not be a power of 2.
- SEL_W, $clog2(N), select/channel-index width (derived; do not override).
- MODE, 0, 0 = external select (sel port), 1 = round-robin arbitration (sel ignored).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i presents a word
- in_ready  out  N  channel i word accepted this cycle (combinational)
- sel  in  SEL_W  channel choice in MODE 0
- out_data  out  WIDTH  registered output word
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts out_data this cycle
- out_chan  out  SEL_W  index of the channel that produced out_data

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_chan=0, round-robin pointer=0. in_ready is 0 while rst=1. Reset mid-transfer discards the held word; no handshake completes in a reset cycle.
- load_en = !out_valid || out_ready. Output register accepts a new word whenever it is empty or is being drained in the same cycle.
- Grant, combinational, at most one bit set:
  - MODE 0: grant[sel]=in_valid[sel]. If sel >= N, no grant.
  - MODE 1: first i with in_valid[i], searching ptr, ptr+1, … N-1, 0, … ptr-1 (wrap modulo N, not 2^SEL_W).
- in_ready[i] = grant[i] && load_en && !rst. A transfer occurs on channel i when in_valid[i] && in_ready[i].
- On a transfer at edge t:
  - out_data <= word from channel i, out_chan <= i, out_valid <= 1, all at t.
  - MODE 1: ptr <= (i==N-1) ? 0 : i+1.
- Pointer update:
  - No transfer: ptr holds.
  - MODE 0: ptr is held at 0.
- If out_valid && out_ready and there is no transfer, out_valid <= 0. out_data and out_chan keep their stale values.
- If out_valid && !out_ready, out_data and out_chan are frozen and all in_ready are 0 (backpressure).
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 word/cycle when out_ready is held high.
- Fairness (MODE 1): with all channels valid continuously, grants cycle 0,1,…,N-1,0. No channel waits more than N-1 transfers.
- Simultaneous drain and load in the same cycle: no bubble. out_valid stays 1 and the new word replaces the old one.
- sel may change every cycle. It is sampled only in the cycle a transfer occurs.
- in_data and in_valid on non-granted channels have no effect.

Decomposition:
- Shared package mux_pkg: localparam MODE_SEL=0, MODE_RR=1, and a function clog2 helper for tools lacking $clog2.
- Sub-module rr_arbiter (parameters N; ports clk, rst, req[N], advance, grant[N]) holds the pointer and the wrap search.
- stream_mux_arb instantiates rr_arbiter only under a MODE==1 generate branch.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_chan=0; first post-reset grant in MODE 1 goes to channel 0.
2. MODE 0, N=4, WIDTH=32: in_data = {3,2,1,0} word-wise, all valid, out_ready=1, sel stepping 0,1,2,3 per cycle -> out_data 0,1,2,3 with out_chan 0,1,2,3, each one cycle after the matching sel; out_valid stays high.
3. MODE 1, N=3 (non-power-of-2), all valid, out_ready=1 for 7 cycles -> out_chan 0,1,2,0,1,2,0 and no grant to index 3. MODE 0 with sel=3 -> no in_ready and out_valid falls to 0.
4. Backpressure: out_ready=0 for 3 cycles after a word 0xDEADBEEF is loaded -> out_data held at 0xDEADBEEF and in_ready=0. Raise out_ready -> the next word appears the following cycle with no bubble.
5. Round-robin skip: MODE 1, ptr=1, only channels 0 and 3 valid -> grant 3, then 0, then 3.
6. Mid-operation reset: assert rst while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, the word is discarded, and ptr returns to 0.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the stream multiplexer family.
//   MODE_SEL : channel chosen by the external sel port
//   MODE_RR  : channel chosen by the round-robin arbiter
//   clog2()  : ceiling log2 for tools that lack $clog2 in parameter context
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Number of bits needed to index 'value' distinct items (value >= 2).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered priority pointer. The search starts at
// the pointer and wraps modulo N (not modulo 2^SEL_W), so non-power-of-two
// channel counts never grant a nonexistent index.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, pointer returns to 0
//   req      in   N   request per channel
//   advance  in   1   the current grant was consumed this cycle
//   grant    out  N   one-hot (or zero) combinational grant
// -----------------------------------------------------------------------------
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W:0]   probe;
  logic             found;

  // One extra bit on the probe lets ptr+k exceed N before it is folded back.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    probe     = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      probe = {1'b0, ptr} + (SEL_W+1)'(k);
      if (probe >= (SEL_W+1)'(N)) begin
        probe = probe - (SEL_W+1)'(N);
      end
      if (!found && req[probe[SEL_W-1:0]]) begin
        grant[probe[SEL_W-1:0]] = 1'b1;
        grant_idx               = probe[SEL_W-1:0];
        found                   = 1'b1;
      end
    end
  end

  // The channel just served drops to lowest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// -----------------------------------------------------------------------------
// stream_mux_arb
// N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes and a
// single output register stage. Channel choice is either the external sel
// port (MODE_SEL) or a round-robin arbiter (MODE_RR).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_data    in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   N        channel i presents a word
//   in_ready   out  N        channel i word accepted this cycle (combinational)
//   sel        in   SEL_W    channel choice in MODE_SEL
//   out_data   out  WIDTH    registered output word
//   out_valid  out  1        out_data holds a word
//   out_ready  in   1        consumer takes out_data this cycle
//   out_chan   out  SEL_W    source channel of out_data
// -----------------------------------------------------------------------------
module stream_mux_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N),
  parameter int MODE  = MODE_SEL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_chan
);

  logic [N-1:0]     grant;
  logic             load_en;
  logic             xfer;
  logic [SEL_W-1:0] xfer_idx;
  logic [WIDTH-1:0] xfer_word;

  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] chan_p1;
  logic             vld_p1;

  // ---- stage p0: grant, handshake and word selection ----
  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
      ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (xfer),
        .grant   (grant)
      );
    end else begin : g_sel
      // sel values at or beyond N address no channel.
      always_comb begin
        grant = '0;
        if ({1'b0, sel} < (SEL_W+1)'(N)) begin
          grant[sel] = in_valid[sel];
        end
      end
    end
  endgenerate

  // The register can take a word when empty or when drained this same cycle.
  assign load_en  = !vld_p1 || out_ready;
  assign in_ready = grant & {N{load_en && !rst}};
  // A grant is only ever raised on a valid channel, so any ready is a transfer.
  assign xfer     = |in_ready;

  always_comb begin
    xfer_idx  = '0;
    xfer_word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        xfer_idx  = SEL_W'(i);
        xfer_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= xfer_word;
      chan_p1 <= xfer_idx;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_chan  = chan_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_stream_mux_arb.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_arb
// Four instances share one stimulus stream:
//   0: MODE_SEL N=4   1: MODE_RR N=4   2: MODE_RR N=3   3: MODE_SEL N=3
// The driver evaluates a reference model of each instance every cycle,
// checks in_ready and pushes every expected output word into a per-instance
// scoreboard queue; the monitor pops and compares whatever the DUTs present.
// -----------------------------------------------------------------------------
module tb_stream_mux_arb;
  import mux_pkg::*;

  localparam int W = 32;
  localparam int NI = 4;
  localparam int NN [NI] = '{4, 4, 3, 3};
  localparam int MD [NI] = '{0, 1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid;
  logic [1:0]     sel;
  logic           out_ready;

  logic [3:0]   ir0, ir1;
  logic [2:0]   ir2, ir3;
  logic [3:0]   irv [NI];
  logic [W-1:0] od  [NI];
  logic         ov  [NI];
  logic [1:0]   oc  [NI];

  assign irv[0] = ir0;
  assign irv[1] = ir1;
  assign irv[2] = {1'b0, ir2};
  assign irv[3] = {1'b0, ir3};

  stream_mux_arb #(.WIDTH(W), .N(4), .MODE(MODE_SEL)) u_sel4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
    .sel(sel), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_chan(oc[0]));

  stream_mux_arb #(.WIDTH(W), .N(4), .MODE(MODE_RR)) u_rr4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir1),
    .sel(sel), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_chan(oc[1]));

  stream_mux_arb #(.WIDTH(W), .N(3), .MODE(MODE_RR)) u_rr3 (
    .clk(clk), .rst(rst), .in_data(in_data[3*W-1:0]), .in_valid(in_valid[2:0]), .in_ready(ir2),
    .sel(sel), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_chan(oc[2]));

  stream_mux_arb #(.WIDTH(W), .N(3), .MODE(MODE_SEL)) u_sel3 (
    .clk(clk), .rst(rst), .in_data(in_data[3*W-1:0]), .in_valid(in_valid[2:0]), .in_ready(ir3),
    .sel(sel), .out_data(od[3]), .out_valid(ov[3]), .out_ready(out_ready), .out_chan(oc[3]));

  typedef struct {
    logic [W-1:0] d;
    int           c;
    int           cyc;
  } ent_t;

  ent_t sbq [NI][$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: priority pointer and output-register occupancy.
  int mptr  [NI] = '{0, 0, 0, 0};
  bit mfull [NI] = '{0, 0, 0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel served by instance k: -1 when nobody is served.
  function automatic int pick(input int k, input logic [3:0] v, input logic [1:0] s);
    if (MD[k] == 0) begin
      if (int'(s) >= NN[k]) return -1;
      return v[s] ? int'(s) : -1;
    end
    for (int j = 0; j < NN[k]; j++) begin
      int c;
      c = (mptr[k] + j) % NN[k];
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [4*W-1:0] pat(input int base);
    logic [4*W-1:0] d;
    for (int i = 0; i < 4; i++) d[i*W +: W] = W'(base + i);
    return d;
  endfunction

  // One clock of stimulus plus the model update for every instance.
  task automatic step(input logic r, input logic [3:0] v, input logic [1:0] s,
                      input logic ordy, input logic [4*W-1:0] d);
    @(negedge clk);
    #1;
    rst = r; in_valid = v; sel = s; out_ready = ordy; in_data = d;
    #1;
    for (int k = 0; k < NI; k++) begin
      int   g;
      bit   load;
      logic [3:0] exp_ir;
      ent_t e;
      g      = r ? -1 : pick(k, v, s);
      load   = !mfull[k] || ordy;
      exp_ir = (g >= 0 && load) ? 4'(1 << g) : 4'd0;
      chk($sformatf("in_ready[u%0d]", k), 64'(irv[k]), 64'(exp_ir));
      if (r) begin
        mfull[k] = 1'b0;
        mptr[k]  = 0;
      end else if (g >= 0 && load) begin
        e.d   = d[g*W +: W];
        e.c   = g;
        e.cyc = cyc;
        sbq[k].push_back(e);
        mfull[k] = 1'b1;
        if (MD[k] == 1) mptr[k] = (g + 1) % NN[k];
      end else if (mfull[k] && ordy) begin
        mfull[k] = 1'b0;
      end
    end
  endtask

  // Monitor: entries stamped before the current cycle are on the output now.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      for (int k = 0; k < NI; k++) begin
        if (rst) begin
          sbq[k].delete();
        end else begin
          bit exp_v;
          exp_v = (sbq[k].size() > 0) && (sbq[k][0].cyc < cyc);
          chk($sformatf("out_valid[u%0d]", k), 64'(ov[k]), 64'(exp_v));
          if (exp_v && ov[k]) begin
            chk($sformatf("out_data[u%0d]", k), 64'(od[k]), 64'(sbq[k][0].d));
            chk($sformatf("out_chan[u%0d]", k), 64'(oc[k]), 64'(sbq[k][0].c));
            if (out_ready) void'(sbq[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*W-1:0] d;
    rst = 1'b1; in_valid = '0; sel = '0; out_ready = 1'b0; in_data = '0;

    // Reset with every channel requesting: nothing may be accepted.
    step(1'b1, 4'hF, 2'd0, 1'b1, pat(0));
    step(1'b1, 4'hF, 2'd2, 1'b1, pat(0));
    @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset out_valid[u%0d]", k), 64'(ov[k]), 64'd0);
      chk($sformatf("reset out_data[u%0d]", k), 64'(od[k]), 64'd0);
      chk($sformatf("reset out_chan[u%0d]", k), 64'(oc[k]), 64'd0);
    end

    // External select stepping through every channel, consumer always ready.
    for (int s = 0; s < 4; s++) step(1'b0, 4'hF, 2'(s), 1'b1, pat(0));

    // Continuous all-valid traffic for the round-robin fairness sequence.
    for (int i = 0; i < 7; i++) step(1'b0, 4'hF, 2'(i % 3), 1'b1, pat(16 + 4*i));

    // sel beyond the channel count of the 3-way instance.
    step(1'b0, 4'hF, 2'd3, 1'b1, pat(64));
    step(1'b0, 4'hF, 2'd3, 1'b1, pat(68));

    // Backpressure on a held 0xDEADBEEF, then release.
    d = pat(80);
    d[W-1:0] = 32'hDEADBEEF;
    step(1'b0, 4'h1, 2'd0, 1'b1, d);
    for (int i = 0; i < 3; i++) step(1'b0, 4'hF, 2'd1, 1'b0, pat(96 + 4*i));
    step(1'b0, 4'hF, 2'd1, 1'b1, pat(112));
    step(1'b0, 4'h0, 2'd0, 1'b1, pat(116));

    // Pointer parked at 1, only channels 0 and 3 requesting.
    step(1'b0, 4'h1, 2'd0, 1'b1, pat(120));
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1001, 2'd3, 1'b1, pat(128 + 4*i));

    // Reset while a word is stalled on the output.
    step(1'b0, 4'hF, 2'd2, 1'b1, pat(144));
    step(1'b0, 4'hF, 2'd2, 1'b0, pat(148));
    step(1'b1, 4'hF, 2'd2, 1'b0, pat(152));
    step(1'b0, 4'hF, 2'd1, 1'b1, pat(156));
    step(1'b0, 4'hF, 2'd1, 1'b1, pat(160));

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) d[i*W +: W] = $urandom;
      step(($urandom_range(0, 39) == 0), 4'($urandom), 2'($urandom),
           ($urandom_range(0, 3) != 0), d);
    end

    // Drain everything that is still in flight.
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 2'd0, 1'b1, '0);
    @(negedge clk);
    #4;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("drained[u%0d]", k), 64'(sbq[k].size()), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
